// File: rtl/up_conv_pkg.sv
// Shared constants, state encoding and channel slicing helper for the up-conversion interpolator.
package up_conv_pkg;

    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned NCH_DEF     = 2;
    localparam int unsigned RATIO_W_DEF = 4;

    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_HOLD = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // LSB position of channel ch inside a packed multi-channel bus
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned dw);
        return ch * dw;
    endfunction

endpackage

// File: rtl/up_conv_sat_scale.sv
// One channel: signed sample times unsigned ratio, saturated back to the signed sample range.
module up_conv_sat_scale
    import up_conv_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RATIO_W_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [RW-1:0] r,
    output logic [DW-1:0] y
);

    localparam int unsigned PW = DW + RW + 1;

    localparam logic signed [PW-1:0] MAX_V = {{(RW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(RW + 2){1'b1}}, {(DW - 1){1'b0}}};

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] r_ext;
    logic signed [PW-1:0] prod;

    // PW bits hold the exact product, so the low bits are correct two's complement
    assign a_ext = {{(RW + 1){a[DW-1]}}, a};
    assign r_ext = {{(DW + 1){1'b0}}, r};
    assign prod  = a_ext * r_ext;

    always_comb begin
        y = prod[DW-1:0];
        if (prod > MAX_V) begin
            y = MAX_V[DW-1:0];
        end else if (prod < MIN_V) begin
            y = MIN_V[DW-1:0];
        end
    end

endmodule

// File: rtl/up_conv_interp.sv
// Integer interpolator: each accepted sample becomes R outputs (zero-stuff or hold).
// Optional gain compensation of the zero-stuff head sample under UP_CONV_INTERP_GAIN_EN.
module up_conv_interp
    import up_conv_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned NCH     = NCH_DEF,
    parameter int unsigned RATIO_W = RATIO_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RATIO_W-1:0]  ratio_i,
    input  logic                mode_i,
    input  logic [NCH*DW-1:0]   x_data_i,
    input  logic                x_valid_i,
    output logic                x_ready_o,
    output logic [NCH*DW-1:0]   y_data_o,
    output logic                y_valid_o,
    input  logic                y_ready_i,
    output logic                busy_o
);

    localparam int unsigned BW = NCH * DW;

    state_e             state_q;
    state_e             state_d;
    logic [BW-1:0]      held_q;
    logic [RATIO_W-1:0] phase_q;
    logic [RATIO_W-1:0] ratio_q;
    logic               mode_q;

    logic [RATIO_W-1:0] r_eff;
    logic               full;
    logic               last;
    logic               fire;
    logic               accept;

    assign r_eff  = (ratio_q == '0) ? RATIO_W'(1) : ratio_q;
    assign full   = (state_q == ST_FULL);
    assign last   = (phase_q == (r_eff - RATIO_W'(1)));
    assign fire   = full & y_ready_i;
    assign accept = x_valid_i & x_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A last-phase fire empties the holder unless a new sample refills it in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (fire && last && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        y_valid_o = 1'b0;
        busy_o    = 1'b0;
        x_ready_o = 1'b1;
        case (state_q)
            ST_FULL: begin
                y_valid_o = 1'b1;
                busy_o    = 1'b1;
                x_ready_o = last & y_ready_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q  <= '0;
            phase_q <= '0;
            ratio_q <= RATIO_W'(1);
            mode_q  <= MODE_ZERO;
        end else if (accept) begin
            held_q  <= x_data_i;
            phase_q <= '0;
            ratio_q <= ratio_i;
            mode_q  <= mode_i;
        end else if (fire) begin
            phase_q <= last ? '0 : (phase_q + RATIO_W'(1));
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0] held_ch;
        logic [DW-1:0] head_ch;

        assign held_ch = held_q[ch_lsb(c, DW) +: DW];

`ifdef UP_CONV_INTERP_GAIN_EN
        logic [DW-1:0] scaled_ch;

        up_conv_sat_scale #(
            .DW (DW),
            .RW (RATIO_W)
        ) u_scale (
            .a (held_ch),
            .r (r_eff),
            .y (scaled_ch)
        );

        assign head_ch = (mode_q == MODE_ZERO) ? scaled_ch : held_ch;
`else
        assign head_ch = held_ch;
`endif

        assign y_data_o[ch_lsb(c, DW) +: DW] =
            !full               ? '0      :
            (phase_q == '0)     ? head_ch :
            (mode_q == MODE_HOLD) ? held_ch : '0;
    end

endmodule

// File: tb/tb_up_conv_interp.sv
// Self-checking bench for up_conv_interp: directed table, hand sequences, and random traffic vs a queue model.
module tb_up_conv_interp;

    localparam int unsigned DW  = 16;
    localparam int unsigned NCH = 2;
    localparam int unsigned RW  = 4;
`ifdef UP_CONV_INTERP_GAIN_EN
    localparam bit GAIN = 1'b1;
`else
    localparam bit GAIN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [RW-1:0]     ratio_i;
    logic              mode_i;
    logic [NCH*DW-1:0] x_data_i;
    logic              x_valid_i;
    logic              x_ready_o;
    logic [NCH*DW-1:0] y_data_o;
    logic              y_valid_o;
    logic              y_ready_i;
    logic              busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    up_conv_interp #(.DW(DW), .NCH(NCH), .RATIO_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ratio_i   (ratio_i),
        .mode_i    (mode_i),
        .x_data_i  (x_data_i),
        .x_valid_i (x_valid_i),
        .x_ready_o (x_ready_o),
        .y_data_o  (y_data_o),
        .y_valid_o (y_valid_o),
        .y_ready_i (y_ready_i),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: value of the first output of a burst for one channel
    function automatic logic [15:0] head_val(input logic [15:0] x, input int r, input logic mode);
        int v;
        if (!GAIN || mode) return x;
        v = int'($signed(x)) * r;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    logic [31:0] exp_q[$];

    function automatic void expand(input logic [31:0] x, input logic [3:0] ratio, input logic mode);
        int r;
        logic [15:0] c0, c1;
        r = (ratio == 4'd0) ? 1 : int'(ratio);
        for (int k = 0; k < r; k++) begin
            if (k == 0) begin
                c0 = head_val(x[15:0], r, mode);
                c1 = head_val(x[31:16], r, mode);
            end else begin
                c0 = mode ? x[15:0] : 16'h0;
                c1 = mode ? x[31:16] : 16'h0;
            end
            exp_q.push_back({c1, c0});
        end
    endfunction

    // Transaction-level monitor: every output fire pops the model queue; stalls must hold output
    logic        stalled = 1'b0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", {31'b0, y_valid_o}, 32'd1);
                chk("stall_data", y_data_o, prev_data);
            end
            if (y_valid_o && y_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL model_extra: got output %h expected none at %0t", y_data_o, $time);
                end else begin
                    chk("model_data", y_data_o, exp_q.pop_front());
                end
            end
            if (x_valid_i && x_ready_o) expand(x_data_i, ratio_i, mode_i);
            stalled   = y_valid_o && !y_ready_i;
            prev_data = y_data_o;
        end
    end

    typedef struct {
        logic [3:0]  ratio;
        logic        mode;
        logic [15:0] x0, x1;
        int          n;
        logic [15:0] f0, f1, r0, r1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic [3:0] ratio, input logic mode,
                                 input logic [15:0] x0, input logic [15:0] x1, input int n,
                                 input logic [15:0] f0, input logic [15:0] f1,
                                 input logic [15:0] r0, input logic [15:0] r1);
        vec_t v;
        v.ratio = ratio; v.mode = mode; v.x0 = x0; v.x1 = x1; v.n = n;
        v.f0 = f0; v.f1 = f1; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    // Single sample with y_ready high; checks every output, x_ready per phase and burst length
    task automatic run_one(input vec_t v);
        int cnt;
        ratio_i   = v.ratio;
        mode_i    = v.mode;
        x_data_i  = {v.x1, v.x0};
        x_valid_i = 1'b1;
        y_ready_i = 1'b1;
        tick();
        x_valid_i = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!y_valid_o) break;
            chk("vec_data", y_data_o, (cnt == 0) ? {v.f1, v.f0} : {v.r1, v.r0});
            chk("vec_busy", {31'b0, busy_o}, 32'd1);
            chk("vec_x_ready", {31'b0, x_ready_o}, {31'b0, (cnt == v.n - 1)});
            cnt++;
            tick();
        end
        chk("vec_count", cnt, v.n);
        chk("vec_idle_busy", {31'b0, busy_o}, 32'd0);
        tick();
    endtask

    initial begin
        logic [15:0] bb_exp [8];
        logic        pat [5];
        int          ph;
        int          bound;
        vec_t        v;

        rst = 1'b1; x_valid_i = 1'b0; x_data_i = '0; ratio_i = '0; mode_i = 1'b0; y_ready_i = 1'b1;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'b0, y_valid_o}, 32'd0);
        chk("rst_data", y_data_o, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_x_ready", {31'b0, x_ready_o}, 32'd1);
        tick();

        tbl.push_back(mkv(4'd8, 1'b0, 16'h1234, 16'hFEDC, 8,
                          GAIN ? 16'h7FFF : 16'h1234, GAIN ? 16'hF6E0 : 16'hFEDC, 16'h0, 16'h0));
        tbl.push_back(mkv(4'd4, 1'b0, 16'h1000, 16'h3000, 4,
                          GAIN ? 16'h4000 : 16'h1000, GAIN ? 16'h7FFF : 16'h3000, 16'h0, 16'h0));
        tbl.push_back(mkv(4'd4, 1'b0, 16'hC000, 16'h0001, 4,
                          GAIN ? 16'h8000 : 16'hC000, GAIN ? 16'h0004 : 16'h0001, 16'h0, 16'h0));
        tbl.push_back(mkv(4'd2, 1'b1, 16'hABCD, 16'h5555, 2, 16'hABCD, 16'h5555, 16'hABCD, 16'h5555));
        tbl.push_back(mkv(4'd15, 1'b0, 16'h8000, 16'h7FFF, 15, 16'h8000, 16'h7FFF, 16'h0, 16'h0));
        tbl.push_back(mkv(4'd0, 1'b1, 16'h0042, 16'hFFFF, 1, 16'h0042, 16'hFFFF, 16'h0, 16'h0));
        tbl.push_back(mkv(4'd1, 1'b0, 16'h1111, 16'h2222, 1, 16'h1111, 16'h2222, 16'h0, 16'h0));
        tbl.push_back(mkv(4'd3, 1'b0, 16'hFFFF, 16'h0002, 3,
                          GAIN ? 16'hFFFD : 16'hFFFF, GAIN ? 16'h0006 : 16'h0002, 16'h0, 16'h0));
        foreach (tbl[i]) run_one(tbl[i]);

        // Back-to-back hold bursts with x_valid held: no bubble between samples
        bb_exp = '{16'h1, 16'h1, 16'h1, 16'h1, 16'h2, 16'h2, 16'h2, 16'h2};
        ratio_i = 4'd4; mode_i = 1'b1; x_data_i = 32'h0000_0001; x_valid_i = 1'b1;
        tick();
        x_data_i = 32'h0000_0002;
        for (int i = 0; i < 8; i++) begin
            logic acc;
            @(negedge clk);
            chk("b2b_valid", {31'b0, y_valid_o}, 32'd1);
            chk("b2b_data", y_data_o, {16'h0, bb_exp[i]});
            acc = x_valid_i && x_ready_o;
            tick();
            if (acc) x_valid_i = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_valid", {31'b0, y_valid_o}, 32'd0);
        tick();

        // Backpressure: y_ready pattern 1,0,0,1,1 on an R=3 zero-stuff burst
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ratio_i = 4'd3; mode_i = 1'b0; x_data_i = 32'h00AA_0055; x_valid_i = 1'b1;
        tick();
        x_valid_i = 1'b0;
        ph = 0;
        for (int i = 0; i < 5; i++) begin
            y_ready_i = pat[i];
            @(negedge clk);
            chk("bp_valid", {31'b0, y_valid_o}, 32'd1);
            chk("bp_data", y_data_o, (ph == 0) ? {head_val(16'h00AA, 3, 1'b0), head_val(16'h0055, 3, 1'b0)} : 32'h0);
            chk("bp_x_ready", {31'b0, x_ready_o}, {31'b0, (ph == 2) && pat[i]});
            if (pat[i]) ph++;
            tick();
        end
        y_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_fires", ph, 3);
        chk("bp_end_valid", {31'b0, y_valid_o}, 32'd0);
        tick();

        // Pass-through with ratio 0 and 1: one output per cycle, equal to input
        for (int rr = 0; rr < 2; rr++) begin
            logic [31:0] smp [3];
            smp = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300};
            ratio_i = 4'(rr); mode_i = 1'b0;
            for (int k = 0; k < 4; k++) begin
                x_valid_i = (k < 3);
                x_data_i  = (k < 3) ? smp[k] : 32'h0;
                @(negedge clk);
                chk("pt_x_ready", {31'b0, x_ready_o}, 32'd1);
                if (k > 0) begin
                    chk("pt_valid", {31'b0, y_valid_o}, 32'd1);
                    chk("pt_data", y_data_o, smp[k-1]);
                end
                tick();
            end
            @(negedge clk);
            chk("pt_end_valid", {31'b0, y_valid_o}, 32'd0);
            tick();
        end

        // Reset at phase 2 of an R=8 burst, then a fresh burst must start at phase 0
        ratio_i = 4'd8; mode_i = 1'b0; x_data_i = 32'h0008_0007; x_valid_i = 1'b1;
        tick();
        x_valid_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'b0, y_valid_o}, 32'd0);
        chk("mid_rst_data", y_data_o, 32'd0);
        chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        chk("mid_rst_x_ready", {31'b0, x_ready_o}, 32'd1);
        tick();
        v = mkv(4'd3, 1'b0, 16'h0011, 16'h0022, 3,
                GAIN ? 16'h0033 : 16'h0011, GAIN ? 16'h0066 : 16'h0022, 16'h0, 16'h0);
        run_one(v);

        // Random traffic: ratio/mode/data change every cycle, checked by the queue model
        for (int c = 0; c < 2000; c++) begin
            x_valid_i = ($urandom_range(0, 3) != 0);
            x_data_i  = $urandom;
            ratio_i   = 4'($urandom_range(0, 15));
            mode_i    = 1'($urandom_range(0, 1));
            y_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        x_valid_i = 1'b0;
        y_ready_i = 1'b1;
        bound = 0;
        while (y_valid_o && bound < 40) begin
            tick();
            bound++;
        end
        @(negedge clk);
        chk("drain_valid", {31'b0, y_valid_o}, 32'd0);
        chk("drain_model_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/up_conv_interp.md
Name: up_conv_interp

Overview:
- Parametrised integer interpolator front end for the modem TX path, run-time ratio 1..2^RATIO_W-1.
- Each accepted multi-channel input sample expands into `ratio` output samples.
  - Mode 0 (zero-stuff): sample followed by zeros.
  - Mode 1 (hold): sample repeated.
- Full valid/ready handshake on both sides; output stalls cleanly under backpressure. Sits between symbol mapper and pulse-shaping FIR.

Parameters:
- DW, 16, bits per channel sample (signed two's complement)
- NCH, 2, number of parallel channels (2 = I/Q)
- RATIO_W, 4, width of run-time ratio input

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ratio_i  in  RATIO_W  interpolation ratio; sampled on each input accept
- mode_i  in  1  0 = zero-stuff, 1 = sample-and-hold; sampled on each input accept
- x_data_i  in  NCH*DW  packed input, channel 0 in bits [DW-1:0]
- x_valid_i  in  1  input valid
- x_ready_o  out  1  input ready
- y_data_o  out  NCH*DW  packed output, same packing
- y_valid_o  out  1  output valid
- y_ready_i  in  1  output ready
- busy_o  out  1  high while a sample is held (full)

Behaviour:
- State: full flag, held sample register, phase counter (RATIO_W bits), latched ratio, latched mode.
- Reset: full=0, phase=0, latched ratio=1, latched mode=0, held data=0. Outputs y_valid_o=0, y_data_o=0, busy_o=0, x_ready_o=1.
- Effective ratio R = latched ratio, with 0 treated as 1.
- y_valid_o = full.
- y_data_o:
  - phase==0: held sample.
  - phase!=0, mode 1: held sample.
  - phase!=0, mode 0: all zeros.
  - When !full: all zeros.
- Output fire = y_valid_o & y_ready_i.
  - Fire with phase < R-1: phase increments.
  - Fire with phase == R-1 ("last"): phase returns to 0 and full clears, unless a new input is accepted in the same cycle.
- x_ready_o = !full | (last & y_ready_i). Combinational path from y_ready_i to x_ready_o is permitted.
- Input accept = x_valid_i & x_ready_o. On accept:
  - load held sample, latch ratio_i and mode_i;
  - set full=1, phase=0.
- Simultaneous last-fire and accept: new sample is shown on the next cycle with no bubble, giving 100% output throughput.
- Latency: a sample accepted at edge t appears on y_data_o with y_valid_o=1 in the cycle after edge t.
- Ratio/mode changes between accepts have no effect on the sample in flight.
- R=1: pure registered pass-through with full throughput.
- y_ready_i low: outputs, phase and held data remain stable; valid is never withdrawn while stalled.
- Reset mid-burst: in-flight sample dropped, state returns to reset values next cycle.

Optional Feature:
- Macro: UP_CONV_INTERP_GAIN_EN.
- When defined, zero-stuff mode only: the phase-0 output equals held sample × R per channel, saturated to signed DW range (max 2^(DW-1)-1, min -2^(DW-1)). Multiply is combinational on the held register, so latency is unchanged.
- Hold mode and zero phases are unaffected.
- When undefined: no multiplier; phase-0 output is the held sample unchanged.

Decomposition:
- Shared package up_conv_pkg:
  - MODE_ZERO=1'b0 and MODE_HOLD=1'b1 constants;
  - default DW/NCH/RATIO_W localparams;
  - per-channel slice helper function.
- Sub-module up_conv_sat_scale: one channel, DW×RATIO_W signed multiply with saturation. Instantiated NCH times, only under the gain macro.

Test Plan:
- Reset, then R=8, mode 0, x=(0x1234,0xFEDC), y_ready_i=1 constant -> 8 valid outputs: (0x1234,0xFEDC) then 7×(0,0). x_ready_o is high in the 8th output cycle.
- R=4, mode 1, inputs back-to-back 0x0001,0x0002 with x_valid_i held -> output 0x0001×4 then 0x0002×4, with no idle cycle between them.
- R=3, mode 0, y_ready_i toggled 1,0,0,1,1 -> outputs stay stable during stall; exactly 3 fires; phase sequence 0,1,2; x_ready_o low while stalled.
- ratio_i=0 and ratio_i=1, stream 0x0100,0x0200,0x0300 -> 3 outputs, one per cycle, identical to input (pass-through).
- Reset asserted at phase 2 of R=8 -> y_valid_o=0 and y_data_o=0 on the next cycle; next accepted sample starts at phase 0.
- UP_CONV_INTERP_GAIN_EN, R=4, mode 0:
  - x=0x1000 -> phase-0 output 0x4000;
  - x=0x3000 -> 0x7FFF;
  - x=0xC000 -> 0x8000.
